pipo_shift_register: RTL and testbench



---
 rtl/pipo_pkg.sv | 11 +
 rtl/pipo_shift_register.sv | 50 +++++
 tb/tb_pipo_shift_register.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipo_pkg.sv
// Shared definitions for the parallel-in/parallel-out holding register.
// Supplies the default data width, the default word type and the default reset word.
package pipo_pkg;

    localparam int unsigned PIPO_DEFAULT_WIDTH = 4;

    typedef logic [PIPO_DEFAULT_WIDTH-1:0] pipo_word_t;

    localparam pipo_word_t PIPO_RESET_VALUE = '0;

endpackage : pipo_pkg

// File: rtl/pipo_shift_register.sv
// Loadable WIDTH-bit staging register between a producer and a consumer.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous, active-low reset; forces the word to RESET_VALUE
//   load         - capture parallel_in on the next rising edge
//   parallel_in  - word to capture
//   parallel_out - current register contents, straight from the flops
module pipo_shift_register
    import pipo_pkg::*;
#(
    parameter int unsigned      WIDTH       = PIPO_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PIPO_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out
);

    // Reject a zero-width register at elaboration.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("pipo_shift_register: WIDTH must be 1 or greater");
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next word: new data when load is high, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = parallel_in;
        end
    end

    // Storage flops; reset takes priority over any clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign parallel_out = q_q;

endmodule : pipo_shift_register

// File: tb/tb_pipo_shift_register.sv
// Directed bench for pipo_shift_register at default parameters.
module tb_pipo_shift_register;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] parallel_in;
    logic [3:0] parallel_out;

    int n_vec;
    int n_miscmp;

    pipo_shift_register dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .parallel_in  (parallel_in),
        .parallel_out (parallel_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] hold_pat [3];
        n_vec       = 0;
        n_miscmp    = 0;
        hold_pat[0] = 4'b0101;
        hold_pat[1] = 4'b1111;
        hold_pat[2] = 4'b0000;

        // Reset held with load active: output pinned to zero.
        reset       = 1'b0;
        load        = 1'b1;
        parallel_in = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            check_vec("reset_hold", parallel_out, 4'b0000);
        end

        // Release reset; first functional edge loads 1010.
        reset       = 1'b1;
        parallel_in = 4'b1010;
        @(negedge clk);
        check_vec("load_1010", parallel_out, 4'b1010);

        // Hold with changing input.
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            parallel_in = hold_pat[i];
            @(negedge clk);
            check_vec("hold_1010", parallel_out, 4'b1010);
        end

        // Reload 0101 then hold two edges.
        parallel_in = 4'b0101;
        load        = 1'b1;
        @(negedge clk);
        check_vec("reload_0101", parallel_out, 4'b0101);
        load        = 1'b0;
        parallel_in = 4'b1100;
        repeat (2) begin
            @(negedge clk);
            check_vec("hold_0101", parallel_out, 4'b0101);
        end

        // Asynchronous reset between edges.
        #2;
        reset       = 1'b0;
        load        = 1'b1;
        parallel_in = 4'b1111;
        #1;
        check_vec("async_reset", parallel_out, 4'b0000);
        @(negedge clk);
        check_vec("reset_over_edge", parallel_out, 4'b0000);

        // Release and load 0011.
        reset       = 1'b1;
        parallel_in = 4'b0011;
        @(negedge clk);
        check_vec("post_reset_0011", parallel_out, 4'b0011);

        // Continuous load, output lags input by one edge.
        parallel_in = 4'b0001;
        #1;
        check_vec("no_comb_path", parallel_out, 4'b0011);
        @(negedge clk);
        check_vec("stream_0001", parallel_out, 4'b0001);
        parallel_in = 4'b0010;
        #1;
        check_vec("stream_lag", parallel_out, 4'b0001);
        @(negedge clk);
        check_vec("stream_0010", parallel_out, 4'b0010);
        parallel_in = 4'b0100;
        @(negedge clk);
        check_vec("stream_0100", parallel_out, 4'b0100);

        // A load pulse between edges has no effect.
        load        = 1'b0;
        parallel_in = 4'b1000;
        #1 load = 1'b1;
        #1 load = 1'b0;
        @(negedge clk);
        check_vec("glitch_ignored", parallel_out, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule : tb_pipo_shift_register
